// File: rtl/risc_mini_pkg.sv
// Shared encodings for the RISC Mini multicycle control unit:
// instruction type/func codes, PC mux selects, FSM states, decode and output bundles.
package risc_mini_pkg;

  localparam logic [3:0] R_TYPE = 4'h0;
  localparam logic [3:0] I_TYPE = 4'h1;
  localparam logic [3:0] J_TYPE = 4'h2;
  localparam logic [3:0] M_TYPE = 4'h3;

  localparam logic [3:0] FN_JUMP   = 4'h0;
  localparam logic [3:0] FN_BRANCH = 4'h1;
  localparam logic [3:0] FN_CALL   = 4'h2;
  localparam logic [3:0] FN_RET    = 4'h3;

  localparam logic [3:0] FN_LOAD  = 4'h0;
  localparam logic [3:0] FN_STORE = 4'h1;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_ALU = 2'd1;
  localparam logic [1:0] PC_SEL_RAS = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_e;

  typedef struct packed {
    logic is_alu;
    logic is_imm;
    logic is_jmp;
    logic is_br;
    logic is_call;
    logic is_ret;
    logic is_ld;
    logic is_st;
    logic illegal;
  } dec_t;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       a_sel;
    logic       b_sel;
    logic       dmem_re;
    logic       dmem_we;
    logic       wb_sel;
    logic       reg_we;
    logic       ras_push;
    logic       ras_pop;
    logic       fault;
    logic       busy;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction/condition/dmem inputs and datapath control outputs.
// master = control unit, slave = datapath / memory side.
interface multicycle_control_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH_W = 3
);
  logic [XLEN-1:0]    inst;
  logic               inst_valid;
  logic [3:0]         ccr;
  logic               dmem_ready;
  logic               ir_we;
  logic               pc_we;
  logic [1:0]         pc_sel;
  logic               a_sel;
  logic               b_sel;
  logic               dmem_re;
  logic               dmem_we;
  logic               wb_sel;
  logic               reg_we;
  logic               ras_push;
  logic               ras_pop;
  logic [DEPTH_W-1:0] depth;
  logic               fault;
  logic               busy;

  modport master (
    input  inst, inst_valid, ccr, dmem_ready,
    output ir_we, pc_we, pc_sel, a_sel, b_sel, dmem_re, dmem_we, wb_sel,
           reg_we, ras_push, ras_pop, depth, fault, busy
  );

  modport slave (
    output inst, inst_valid, ccr, dmem_ready,
    input  ir_we, pc_we, pc_sel, a_sel, b_sel, dmem_re, dmem_we, wb_sel,
           reg_we, ras_push, ras_pop, depth, fault, busy
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational classifier of the latched IR type/func fields.
module ctrl_decode
  import risc_mini_pkg::*;
(
  input  logic [7:0] ir_i,
  output dec_t       dec_o
);
  logic [3:0] typ;
  logic [3:0] func;

  assign typ  = ir_i[3:0];
  assign func = ir_i[7:4];

  always_comb begin
    dec_o = '0;
    case (typ)
      R_TYPE: dec_o.is_alu = 1'b1;
      I_TYPE: begin
        dec_o.is_alu = 1'b1;
        dec_o.is_imm = 1'b1;
      end
      J_TYPE: begin
        case (func)
          FN_JUMP:   dec_o.is_jmp  = 1'b1;
          FN_BRANCH: dec_o.is_br   = 1'b1;
          FN_CALL:   dec_o.is_call = 1'b1;
          FN_RET:    dec_o.is_ret  = 1'b1;
          default:   dec_o.illegal = 1'b1;
        endcase
      end
      M_TYPE: begin
        case (func)
          FN_LOAD:  dec_o.is_ld   = 1'b1;
          FN_STORE: dec_o.is_st   = 1'b1;
          default:  dec_o.illegal = 1'b1;
        endcase
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// RISC Mini multicycle control FSM with bounded call-depth tracking.
// ILLEGAL_TRAP_EN: undefined encodings fault in DECODE instead of retiring as a NOP.
module multicycle_control
  import risc_mini_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned DEPTH_W   = $clog2(RAS_DEPTH + 1)
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master ctl_if
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(RAS_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_e             state_q, state_d;
  logic [11:0]        ir_q, ir_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  ctrl_out_t          out_q, out_d;
  dec_t               dec;
  logic               taken;
  logic               unused_inst;

  ctrl_decode u_decode (
    .ir_i  (ir_q[7:0]),
    .dec_o (dec)
  );

  assign taken       = |(ctl_if.ccr & ir_q[11:8]);
  assign unused_inst = ^ctl_if.inst[XLEN-1:12];

  // Outputs are registered: each cycle shows the decisions of the previous cycle's state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      depth_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      depth_q <= depth_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    depth_d = depth_q;
    out_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (ctl_if.inst_valid) begin
          out_d.ir_we = 1'b1;
          ir_d        = ctl_if.inst[11:0];
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        out_d.busy = 1'b1;
        state_d    = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (dec.illegal) state_d = S_FAULT;
`endif
      end
      S_EXEC: begin
        out_d.busy  = 1'b1;
        out_d.pc_we = 1'b1;
        state_d     = S_FETCH;
        if (dec.is_alu) state_d = S_WB;
        if (dec.is_imm || dec.is_ld || dec.is_st) out_d.b_sel = 1'b1;
        if (dec.is_ld || dec.is_st) state_d = S_MEM;
        if (dec.is_jmp || (dec.is_br && taken)) begin
          out_d.a_sel  = 1'b1;
          out_d.pc_sel = PC_SEL_ALU;
        end
        // Overflowing or underflowing the return stack is fatal, with no side effects.
        if (dec.is_call) begin
          if (depth_q == DEPTH_MAX) begin
            out_d.pc_we = 1'b0;
            state_d     = S_FAULT;
          end else begin
            out_d.ras_push = 1'b1;
            out_d.a_sel    = 1'b1;
            out_d.pc_sel   = PC_SEL_ALU;
            depth_d        = depth_q + DEPTH_ONE;
          end
        end
        if (dec.is_ret) begin
          if (depth_q == '0) begin
            out_d.pc_we = 1'b0;
            state_d     = S_FAULT;
          end else begin
            out_d.ras_pop = 1'b1;
            out_d.pc_sel  = PC_SEL_RAS;
            depth_d       = depth_q - DEPTH_ONE;
          end
        end
`ifndef ILLEGAL_TRAP_EN
        if (dec.illegal) state_d = S_FETCH;
`endif
      end
      S_MEM: begin
        out_d.busy  = 1'b1;
        out_d.b_sel = 1'b1;
        if (ctl_if.dmem_ready) begin
          state_d = dec.is_ld ? S_WB : S_FETCH;
        end else begin
          out_d.dmem_re = dec.is_ld;
          out_d.dmem_we = dec.is_st;
        end
      end
      S_WB: begin
        out_d.busy   = 1'b1;
        out_d.reg_we = 1'b1;
        out_d.wb_sel = dec.is_ld;
        state_d      = S_FETCH;
      end
      S_FAULT: begin
        out_d.busy  = 1'b1;
        out_d.fault = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ctl_if.ir_we    = out_q.ir_we;
  assign ctl_if.pc_we    = out_q.pc_we;
  assign ctl_if.pc_sel   = out_q.pc_sel;
  assign ctl_if.a_sel    = out_q.a_sel;
  assign ctl_if.b_sel    = out_q.b_sel;
  assign ctl_if.dmem_re  = out_q.dmem_re;
  assign ctl_if.dmem_we  = out_q.dmem_we;
  assign ctl_if.wb_sel   = out_q.wb_sel;
  assign ctl_if.reg_we   = out_q.reg_we;
  assign ctl_if.ras_push = out_q.ras_push;
  assign ctl_if.ras_pop  = out_q.ras_pop;
  assign ctl_if.fault    = out_q.fault;
  assign ctl_if.busy     = out_q.busy;
  assign ctl_if.depth    = depth_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-summary vector table, directed corner
// sequences and randomized instruction streams against a per-instruction reference model.
module tb_multicycle_control;
  import risc_mini_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned DEPTH_W   = $clog2(RAS_DEPTH + 1);

  typedef struct packed {
    logic ir_we; logic pc_we; logic [1:0] pc_sel; logic a_sel; logic b_sel;
    logic re; logic we; logic wb_sel; logic reg_we; logic push; logic pop;
    logic [DEPTH_W-1:0] depth; logic fault; logic busy;
  } obs_t;

  typedef struct {
    string name; logic [31:0] inst; logic [3:0] ccr; int w;
    int lat; int pc_sel; int reg_n; int wb_sel; int re_n; int we_n; int b_sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_depth = 0;
  bit   m_fault = 1'b0;
  vec_t vt [10];

  always #5 clk = ~clk;

  multicycle_control_if #(.XLEN(XLEN), .DEPTH_W(DEPTH_W)) bus ();

  multicycle_control #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .rst(rst), .ctl_if(bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o.ir_we = bus.ir_we;   o.pc_we = bus.pc_we;   o.pc_sel = bus.pc_sel;
    o.a_sel = bus.a_sel;   o.b_sel = bus.b_sel;   o.re = bus.dmem_re;
    o.we = bus.dmem_we;    o.wb_sel = bus.wb_sel; o.reg_we = bus.reg_we;
    o.push = bus.ras_push; o.pop = bus.ras_pop;   o.depth = bus.depth;
    o.fault = bus.fault;   o.busy = bus.busy;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t e = '0;
    e.depth = DEPTH_W'(m_depth);
    return e;
  endfunction

  function automatic obs_t fault_obs();
    obs_t e = idle_obs();
    e.fault = 1'b1;
    e.busy  = 1'b1;
    return e;
  endfunction

  task automatic check_obs(input obs_t e, input string name);
    obs_t a = sample();
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, a, e);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: drive inputs at negedge, sample 1ns after the following posedge.
  task automatic cyc(input logic v, input logic [31:0] i, input logic [3:0] c, input logic rdy);
    @(negedge clk);
    bus.inst = i; bus.inst_valid = v; bus.ccr = c; bus.dmem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    obs_t z = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1; bus.inst_valid = 1'b1; bus.inst = 32'h22; bus.dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      check_obs(z, "reset");
    end
    @(negedge clk);
    rst = 1'b0; bus.inst_valid = 1'b0;
    m_depth = 0; m_fault = 1'b0;
  endtask

  task automatic model_idle();
    cyc(1'b0, $urandom(), 4'($urandom()), 1'($urandom()));
    check_obs(m_fault ? fault_obs() : idle_obs(), "idle");
  endtask

  // Reference: expected per-cycle outputs of one instruction from its type/func semantics.
  task automatic model_inst(input logic [31:0] inst, input logic [3:0] c, input int w);
    obs_t e;
    logic [3:0] t, f;
    bit illegal, to_mem, to_wb;
    t = inst[3:0]; f = inst[7:4];
    if (m_fault) begin
      cyc(1'b1, inst, c, 1'b1); check_obs(fault_obs(), "fault_hold"); return;
    end
    cyc(1'b1, inst, c, 1'b0);
    e = idle_obs(); e.ir_we = 1'b1; check_obs(e, "fetch");
    cyc(1'b0, $urandom(), c, 1'b0);
    e = idle_obs(); e.busy = 1'b1; check_obs(e, "decode");
    illegal = (t > 4'h3) || (t == J_TYPE && f > 4'h3) || (t == M_TYPE && f > 4'h1);
`ifdef ILLEGAL_TRAP_EN
    if (illegal) begin
      m_fault = 1'b1; cyc(1'b0, $urandom(), c, 1'b0); check_obs(fault_obs(), "trap"); return;
    end
`endif
    cyc(1'b0, $urandom(), c, 1'b0);
    e = idle_obs(); e.busy = 1'b1;
    if (t == J_TYPE && ((f == 4'h2 && m_depth == RAS_DEPTH) || (f == 4'h3 && m_depth == 0))) begin
      check_obs(e, "exec_fault");
      m_fault = 1'b1;
      cyc(1'b0, $urandom(), c, 1'b0); check_obs(fault_obs(), "fault_set");
      return;
    end
    e.pc_we = 1'b1; to_mem = 1'b0; to_wb = 1'b0;
    if (!illegal) begin
      case (t)
        4'h0: to_wb = 1'b1;
        4'h1: begin e.b_sel = 1'b1; to_wb = 1'b1; end
        4'h3: begin e.b_sel = 1'b1; to_mem = 1'b1; end
        default: begin
          if (f == 4'h3) begin
            m_depth--; e.pop = 1'b1; e.pc_sel = 2'd2;
          end else if (f != 4'h1 || (c & inst[11:8]) != 4'h0) begin
            e.a_sel = 1'b1; e.pc_sel = 2'd1;
          end
          if (f == 4'h2) begin m_depth++; e.push = 1'b1; end
        end
      endcase
    end
    e.depth = DEPTH_W'(m_depth);
    check_obs(e, "exec");
    if (to_mem) begin
      for (int k = 0; k <= w; k++) begin
        cyc(1'b0, $urandom(), c, 1'(k == w));
        e = idle_obs(); e.busy = 1'b1; e.b_sel = 1'b1;
        if (k < w) begin e.re = (f == 4'h0); e.we = (f == 4'h1); end
        check_obs(e, "mem");
      end
      to_wb = (f == 4'h0);
    end
    if (to_wb) begin
      cyc(1'b0, $urandom(), c, 1'b0);
      e = idle_obs(); e.busy = 1'b1; e.reg_we = 1'b1; e.wb_sel = to_mem;
      check_obs(e, "wb");
    end
  endtask

  // Summarise one instruction's whole execution and compare to a table record.
  task automatic run_vec(input vec_t v);
    obs_t a;
    int busy_n = 0, reg_n = 0, re_n = 0, we_n = 0, psel = -1, pwe = 0, bs = 0, wbs = 0;
    bit done = 1'b0;
    cyc(1'b1, v.inst, v.ccr, 1'b0);
    for (int k = 1; k < 20 && !done; k++) begin
      cyc(1'b0, 32'h0, v.ccr, 1'(k >= 3 + v.w));
      a = sample();
      if (!a.busy) done = 1'b1;
      else begin
        busy_n++;
        if (a.pc_we) begin pwe++; psel = int'(a.pc_sel); end
        if (a.reg_we) begin reg_n++; wbs = int'(a.wb_sel); end
        if (a.re) re_n++;
        if (a.we) we_n++;
        if (a.b_sel) bs = 1;
      end
    end
    if (!done) begin
      n_chk++; $display("FAIL %s_timeout: still busy after 20 cycles", v.name);
    end
    check_int({v.name, "_lat"}, busy_n + 1, v.lat);
    check_int({v.name, "_pc_we"}, pwe, 1);
    check_int({v.name, "_pc_sel"}, psel, v.pc_sel);
    check_int({v.name, "_reg_we"}, reg_n, v.reg_n);
    check_int({v.name, "_wb_sel"}, wbs, v.wb_sel);
    check_int({v.name, "_re"}, re_n, v.re_n);
    check_int({v.name, "_we"}, we_n, v.we_n);
    check_int({v.name, "_b_sel"}, bs, v.b_sel);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x = $urandom();
    int r = $urandom_range(0, 9);
    if (r == 0)      x[3:0] = 4'($urandom_range(4, 15));
    else if (r == 1) x[3:0] = 4'h0;
    else if (r == 2) x[3:0] = 4'h1;
    else if (r < 5)  begin x[3:0] = 4'h3; x[7:4] = 4'($urandom_range(0, 2)); end
    else             begin x[3:0] = 4'h2; x[7:4] = 4'($urandom_range(0, 4)); end
    return x;
  endfunction

  initial begin
    bus.inst = '0; bus.inst_valid = 1'b0; bus.ccr = '0; bus.dmem_ready = 1'b0;
    // name, inst, ccr, wait, latency, pc_sel, reg_we count, wb_sel, re/we cycles, b_sel
    vt[0] = '{"alu_i",   32'h0000_0001, 4'h0,    0, 4, 0, 1, 0, 0, 0, 1};
    vt[1] = '{"alu_r",   32'hABCD_E070, 4'h0,    0, 4, 0, 1, 0, 0, 0, 0};
    vt[2] = '{"ld_w3",   32'h0000_0003, 4'h0,    3, 8, 0, 1, 1, 3, 0, 1};
    vt[3] = '{"ld_w0",   32'h0000_0003, 4'h0,    0, 5, 0, 1, 1, 0, 0, 1};
    vt[4] = '{"st_w2",   32'h0000_0013, 4'h0,    2, 6, 0, 0, 0, 0, 2, 1};
    vt[5] = '{"br_tk",   32'h0000_0112, 4'b0001, 0, 3, 1, 0, 0, 0, 0, 0};
    vt[6] = '{"br_nt",   32'h0000_0112, 4'b0000, 0, 3, 0, 0, 0, 0, 0, 0};
    vt[7] = '{"br_mask", 32'h0000_0C12, 4'b0100, 0, 3, 1, 0, 0, 0, 0, 0};
    vt[8] = '{"br_miss", 32'h0000_0C12, 4'b0011, 0, 3, 0, 0, 0, 0, 0, 0};
    vt[9] = '{"jump",    32'h0000_0002, 4'h0,    0, 3, 1, 0, 0, 0, 0, 0};

    do_reset();
    foreach (vt[i]) run_vec(vt[i]);

    model_inst(32'h0000_0001, 4'h0, 0);
    model_inst(32'h0000_0003, 4'h0, 3);
    model_inst(32'h0000_0112, 4'b0001, 0);
    model_inst(32'h0000_0112, 4'b0000, 0);

    for (int i = 0; i < 5; i++) model_inst(32'h0000_0022, 4'h0, 0);
    check_int("call_depth", int'(bus.depth), RAS_DEPTH);
    check_int("call_fault", int'(bus.fault), 1);
    model_idle();

    do_reset();
    model_inst(32'h0000_0032, 4'h0, 0);
    check_int("ret_fault", int'(bus.fault), 1);
    do_reset();
    model_idle();
    check_int("ret_cleared", int'(bus.fault), 0);

    model_inst(32'h0000_000F, 4'h0, 0);
    model_idle();
    if (m_fault) do_reset();
    model_inst(32'h0000_0001, 4'h0, 0);

    do_reset();
    cyc(1'b1, 32'h0000_0013, 4'h0, 1'b0);
    cyc(1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 32'h0, 4'h0, 1'b0);
    check_int("mid_mem_we", int'(bus.dmem_we), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_int("mid_mem_drop", int'(bus.dmem_we), 0);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      if (m_fault) do_reset();
      if ($urandom_range(0, 3) == 0) model_idle();
      model_inst(rand_inst(), 4'($urandom()), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
